pio_poll_master: RTL

- Avalon-MM read master that polls the data register (offset 0) of an input-PIO slave at a fixed period.
- Captures each read result and presents it downstream on a valid/ready stream, optionally only when the value changes.
- Sits between the PIO input slave and consumer logic, such as a cursor/position tracker, so the consumer needs no bus interface.

---
 rtl/pio_poll_master.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pio_poll_master.sv
// Avalon-MM read master that periodically polls a PIO data register and
// forwards the captured value on a one-entry valid/ready output register,
// optionally suppressing samples equal to the previously captured value.
module pio_poll_master #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 2,
  parameter int DATA_ADDR    = 0,
  parameter int POLL_PERIOD  = 50000,
  parameter int READ_LATENCY = 1,
  parameter int CHANGE_ONLY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int CNT_W = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LAT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] last_value;
  logic              first_flag;
  logic              tick;
  logic              capture;
  logic              emit;
  logic              handshake;

  // The polled register never moves, so the address is a constant.
  assign avm_address = ADDR_W'(DATA_ADDR);

  assign tick      = enable && (count == CNT_LAST);
  assign capture   = (state == LAT) && (lat_cnt == LAT_LAST);
  assign emit      = capture && ((CHANGE_ONLY == 0) || first_flag ||
                                 (avm_readdata != last_value));
  assign handshake = sample_valid && sample_ready;

  // Poll timer: free-runs over one period while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Read transaction FSM; ticks outside IDLE are simply ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      avm_read <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= REQ;
            avm_read <= 1'b1;
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            state    <= LAT;
            avm_read <= 1'b0;
            lat_cnt  <= LAT_W'(1);
          end
        end
        LAT: begin
          if (capture) begin
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

  // Change detection history: last captured value and the first-capture flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_value <= '0;
      first_flag <= 1'b1;
    end else if (capture) begin
      last_value <= avm_readdata;
      first_flag <= 1'b0;
    end
  end

  // One-entry output register; a new sample always replaces the held one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else if (emit) begin
      sample_data  <= avm_readdata;
      sample_valid <= 1'b1;
    end else if (handshake) begin
      sample_valid <= 1'b0;
    end
  end

  // Sticky overrun: losing an unconsumed sample wins over a clear request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (emit && sample_valid && !sample_ready) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
